dcache_port_arbiter: RTL and testbench

Arbitrates the single data-cache port between the memory-read requester (operand fetch) and the write-back store requester. Grants one transaction at a time, drives the cache request channel, and routes read responses and write acknowledgements back to the owner. A watchdog flags transactions that stall on the cache. Sits between the pipeline memory stages and the data-cache bus.

---
 rtl/dcache_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - single data-cache port arbiter between operand-fetch reads and write-back stores
module dcache_port_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TAG_W          = 13,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_reqcyc_in,
    input  logic [ADDR_W-1:0] rd_req_in,
    input  logic [TAG_W-1:0]  rd_reqtag_in,
    output logic              rd_reqack_out,
    output logic              rd_respcyc_out,
    output logic [DATA_W-1:0] rd_resp_out,
    input  logic              rd_respack_in,
    input  logic              wr_reqcyc_in,
    input  logic [ADDR_W-1:0] wr_req_in,
    input  logic [TAG_W-1:0]  wr_reqtag_in,
    input  logic [DATA_W-1:0] wr_reqdata_in,
    output logic              wr_reqack_out,
    output logic              wr_writeack_out,
    output logic              bus_reqcyc_out,
    output logic [ADDR_W-1:0] bus_req_out,
    output logic [DATA_W-1:0] bus_reqdata_out,
    output logic [TAG_W-1:0]  bus_reqtag_out,
    input  logic              bus_reqack_in,
    input  logic              bus_respcyc_in,
    input  logic [DATA_W-1:0] bus_resp_in,
    input  logic [TAG_W-1:0]  bus_resptag_in,
    output logic              bus_respack_out,
    input  logic              bus_writeack_in,
    output logic              busy_out,
    output logic              owner_out,
    output logic              error_out
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, RESP_RD, WAIT_WR} state_t;

    state_t            state, stateNext;
    logic              lastGrant, lastGrantNext, grantWrite;
    logic [CNT_W-1:0]  wdogCount, wdogCountNext;
    logic              rdReqAckNext, wrReqAckNext, rdRespCycNext, wrWriteAckNext;
    logic              busReqCycNext, busRespAckNext, ownerNext, errorNext, busyNext;
    logic [DATA_W-1:0] rdRespNext, busReqDataNext;
    logic [ADDR_W-1:0] busReqNext;
    logic [TAG_W-1:0]  busReqTagNext;

    // Round robin on a tie: grant whichever side did not win last time.
    assign grantWrite = wr_reqcyc_in && (!rd_reqcyc_in || !lastGrant);

    always_comb begin
        stateNext      = state;
        lastGrantNext  = lastGrant;
        wdogCountNext  = wdogCount;
        rdReqAckNext   = 1'b0;
        wrReqAckNext   = 1'b0;
        busRespAckNext = 1'b0;
        wrWriteAckNext = 1'b0;
        rdRespCycNext  = rd_respcyc_out;
        rdRespNext     = rd_resp_out;
        busReqCycNext  = bus_reqcyc_out;
        busReqNext     = bus_req_out;
        busReqDataNext = bus_reqdata_out;
        busReqTagNext  = bus_reqtag_out;
        ownerNext      = owner_out;
        case (state)
            IDLE: begin
                if (rd_reqcyc_in || wr_reqcyc_in) begin
                    stateNext     = ISSUE;
                    lastGrantNext = grantWrite;
                    ownerNext     = grantWrite;
                    wdogCountNext = '0;
                    busReqCycNext = 1'b1;
                    if (grantWrite) begin
                        busReqNext     = wr_req_in;
                        busReqDataNext = wr_reqdata_in;
                        busReqTagNext  = wr_reqtag_in;
                        wrReqAckNext   = 1'b1;
                    end else begin
                        busReqNext     = rd_req_in;
                        busReqDataNext = '0;
                        busReqTagNext  = rd_reqtag_in;
                        rdReqAckNext   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus_reqack_in) begin
                    busReqCycNext = 1'b0;
                    stateNext     = owner_out ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Responses carrying another tag belong to someone else; leave them unacknowledged.
                if (bus_respcyc_in && (bus_resptag_in == bus_reqtag_out)) begin
                    rdRespNext     = bus_resp_in;
                    rdRespCycNext  = 1'b1;
                    busRespAckNext = 1'b1;
                    stateNext      = RESP_RD;
                end
            end
            RESP_RD: begin
                if (rd_respack_in) begin
                    rdRespCycNext = 1'b0;
                    stateNext     = IDLE;
                end
            end
            WAIT_WR: begin
                if (bus_writeack_in) begin
                    wrWriteAckNext = 1'b1;
                    stateNext      = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if ((state == ISSUE || state == WAIT_RD || state == WAIT_WR) && wdogCount != WDOG_MAX) begin
            wdogCountNext = wdogCount + CNT_W'(1);
        end
        errorNext = error_out || (wdogCountNext == WDOG_MAX);
        busyNext  = (stateNext != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            lastGrant       <= 1'b1;
            wdogCount       <= '0;
            rd_reqack_out   <= 1'b0;
            wr_reqack_out   <= 1'b0;
            rd_respcyc_out  <= 1'b0;
            rd_resp_out     <= '0;
            wr_writeack_out <= 1'b0;
            bus_reqcyc_out  <= 1'b0;
            bus_req_out     <= '0;
            bus_reqdata_out <= '0;
            bus_reqtag_out  <= '0;
            bus_respack_out <= 1'b0;
            busy_out        <= 1'b0;
            owner_out       <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            state           <= stateNext;
            lastGrant       <= lastGrantNext;
            wdogCount       <= wdogCountNext;
            rd_reqack_out   <= rdReqAckNext;
            wr_reqack_out   <= wrReqAckNext;
            rd_respcyc_out  <= rdRespCycNext;
            rd_resp_out     <= rdRespNext;
            wr_writeack_out <= wrWriteAckNext;
            bus_reqcyc_out  <= busReqCycNext;
            bus_req_out     <= busReqNext;
            bus_reqdata_out <= busReqDataNext;
            bus_reqtag_out  <= busReqTagNext;
            bus_respack_out <= busRespAckNext;
            busy_out        <= busyNext;
            owner_out       <= ownerNext;
            error_out       <= errorNext;
        end
    end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - randomized scoreboard bench for dcache_port_arbiter
module tb_dcache_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rd_reqcyc_in, rd_respack_in, wr_reqcyc_in;
    logic [AW-1:0] rd_req_in, wr_req_in;
    logic [TW-1:0] rd_reqtag_in, wr_reqtag_in;
    logic [DW-1:0] wr_reqdata_in;
    logic          rd_reqack_out, rd_respcyc_out, wr_reqack_out, wr_writeack_out;
    logic [DW-1:0] rd_resp_out, bus_reqdata_out, bus_resp_in;
    logic          bus_reqcyc_out, bus_reqack_in, bus_respcyc_in, bus_respack_out, bus_writeack_in;
    logic [AW-1:0] bus_req_out;
    logic [TW-1:0] bus_reqtag_out, bus_resptag_in;
    logic          busy_out, owner_out, error_out;

    dcache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .rd_reqcyc_in(rd_reqcyc_in), .rd_req_in(rd_req_in), .rd_reqtag_in(rd_reqtag_in),
        .rd_reqack_out(rd_reqack_out), .rd_respcyc_out(rd_respcyc_out), .rd_resp_out(rd_resp_out),
        .rd_respack_in(rd_respack_in),
        .wr_reqcyc_in(wr_reqcyc_in), .wr_req_in(wr_req_in), .wr_reqtag_in(wr_reqtag_in),
        .wr_reqdata_in(wr_reqdata_in), .wr_reqack_out(wr_reqack_out), .wr_writeack_out(wr_writeack_out),
        .bus_reqcyc_out(bus_reqcyc_out), .bus_req_out(bus_req_out), .bus_reqdata_out(bus_reqdata_out),
        .bus_reqtag_out(bus_reqtag_out), .bus_reqack_in(bus_reqack_in),
        .bus_respcyc_in(bus_respcyc_in), .bus_resp_in(bus_resp_in), .bus_resptag_in(bus_resptag_in),
        .bus_respack_out(bus_respack_out), .bus_writeack_in(bus_writeack_in),
        .busy_out(busy_out), .owner_out(owner_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } txn_t;

    txn_t rdQ[$];
    txn_t wrQ[$];
    txn_t cur;
    int   checks = 0;
    int   errors = 0;
    int   nReads = 0;
    int   nWrites = 0;
    bit   randomMode = 0;
    bit   cacheHold = 0;
    bit   wrHold = 0;

    // transaction-level reference state
    bit mBusy, mLast, mOwner, mAcked, g;
    bit eRdAck, eWrAck, eBusReq, eRespack, eRespcyc, eWrDone, eBusy;

    function automatic logic [DW-1:0] memFn(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'hDEADBEEF, a[63:32] + 32'h5555_0000};
    endfunction

    task automatic chkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkAllZero(input string tagName);
        chk64({tagName, "_outs"}, {rd_reqack_out, rd_respcyc_out, wr_reqack_out, wr_writeack_out,
              bus_reqcyc_out, bus_respack_out, busy_out, owner_out, error_out}, 64'd0);
        chk64({tagName, "_rd_resp"}, rd_resp_out, 64'd0);
        chk64({tagName, "_bus_req"}, bus_req_out, 64'd0);
        chk64({tagName, "_bus_data"}, bus_reqdata_out, 64'd0);
        chk64({tagName, "_bus_tag"}, 64'(bus_reqtag_out), 64'd0);
    endtask

    task automatic issueRead(input logic [AW-1:0] a, input logic [TW-1:0] t);
        txn_t x;
        x.addr = a; x.tag = t; x.data = memFn(a);
        rdQ.push_back(x);
        rd_req_in = a; rd_reqtag_in = t; rd_reqcyc_in = 1'b1;
    endtask

    task automatic issueWrite(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [DW-1:0] d);
        txn_t x;
        x.addr = a; x.tag = t; x.data = d;
        wrQ.push_back(x);
        wr_req_in = a; wr_reqtag_in = t; wr_reqdata_in = d; wr_reqcyc_in = 1'b1;
    endtask

    // read requester
    initial begin
        rd_reqcyc_in = 0; rd_respack_in = 0; rd_req_in = '0; rd_reqtag_in = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                rd_reqcyc_in = 0; rd_respack_in = 0;
            end else begin
                rd_respack_in = rd_respcyc_out && ($urandom_range(0, 1) == 1);
                if (rd_reqcyc_in && rd_reqack_out) rd_reqcyc_in = 0;
                else if (!rd_reqcyc_in && randomMode && $urandom_range(0, 2) == 0)
                    issueRead({$urandom, $urandom}, TW'($urandom_range(0, 8191)));
            end
        end
    end

    // write requester
    initial begin
        wr_reqcyc_in = 0; wr_req_in = '0; wr_reqtag_in = '0; wr_reqdata_in = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) wr_reqcyc_in = 0;
            else if (wr_reqcyc_in && wr_reqack_out) wr_reqcyc_in = 0;
            else if (!wr_reqcyc_in && randomMode && $urandom_range(0, 2) == 0)
                issueWrite({$urandom, $urandom}, TW'($urandom_range(0, 8191)), {$urandom, $urandom});
        end
    end

    // cache model: acks, optional wrong-tag response, then data from memFn or a write ack
    initial begin
        logic [AW-1:0] a;
        logic [TW-1:0] t;
        bit            isWr;
        int            to;
        bus_reqack_in = 0; bus_respcyc_in = 0; bus_resp_in = '0; bus_resptag_in = '0; bus_writeack_in = 0;
        forever begin
            @(posedge clk); #1;
            if (reset && bus_reqcyc_out && !bus_reqack_in) begin
                isWr = owner_out; a = bus_req_out; t = bus_reqtag_out;
                while (cacheHold) begin @(posedge clk); #1; end
                repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                bus_reqack_in = 1;
                @(posedge clk); #1;
                bus_reqack_in = 0;
                if (!isWr) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus_respcyc_in = 1; bus_resp_in = ~memFn(a); bus_resptag_in = t ^ TW'(3);
                        @(posedge clk); #1;
                        bus_respcyc_in = 0;
                    end
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                    bus_respcyc_in = 1; bus_resp_in = memFn(a); bus_resptag_in = t;
                    to = 0;
                    do begin @(posedge clk); #1; to++; end while (!bus_respack_out && reset && to < 20);
                    if (reset) chkBit("bus_respack_seen", bus_respack_out, 1'b1);
                    bus_respcyc_in = 0;
                end else begin
                    while (wrHold && reset) begin @(posedge clk); #1; end
                    if (reset) begin
                        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                        bus_writeack_in = 1;
                        @(posedge clk); #1;
                        bus_writeack_in = 0;
                    end
                end
            end
        end
    end

    // monitor: compare outputs with last cycle's prediction, then predict the next cycle
    always @(negedge clk) begin
        if (!reset) begin
            mBusy = 0; mLast = 1; mOwner = 0; mAcked = 0;
            eRdAck = 0; eWrAck = 0; eBusReq = 0; eRespack = 0; eRespcyc = 0; eWrDone = 0; eBusy = 0;
        end else begin
            chkBit("rd_reqack", rd_reqack_out, eRdAck);
            chkBit("wr_reqack", wr_reqack_out, eWrAck);
            chkBit("bus_reqcyc", bus_reqcyc_out, eBusReq);
            chkBit("bus_respack", bus_respack_out, eRespack);
            chkBit("rd_respcyc", rd_respcyc_out, eRespcyc);
            chkBit("wr_writeack", wr_writeack_out, eWrDone);
            chkBit("busy", busy_out, eBusy);
            if (eRdAck || eWrAck) begin
                chkBit("owner", owner_out, mOwner);
                chk64("bus_addr", bus_req_out, cur.addr);
                chk64("bus_tag", 64'(bus_reqtag_out), 64'(cur.tag));
                if (eWrAck) chk64("bus_wdata", bus_reqdata_out, cur.data);
            end
            if (eRespack) chk64("rd_resp", rd_resp_out, cur.data);
            if (randomMode) chkBit("error_clear", error_out, 1'b0);

            eRdAck = 0; eWrAck = 0; eRespack = 0; eWrDone = 0;
            if (!mBusy) begin
                if (rd_reqcyc_in || wr_reqcyc_in) begin
                    g = (rd_reqcyc_in && wr_reqcyc_in) ? !mLast : wr_reqcyc_in;
                    mLast = g; mOwner = g; mBusy = 1; mAcked = 0;
                    if (g) begin
                        chkBit("wr_queue_nonempty", wrQ.size() > 0, 1'b1);
                        if (wrQ.size() > 0) cur = wrQ.pop_front();
                    end else begin
                        chkBit("rd_queue_nonempty", rdQ.size() > 0, 1'b1);
                        if (rdQ.size() > 0) cur = rdQ.pop_front();
                    end
                    eRdAck = !g; eWrAck = g; eBusReq = 1;
                end
            end else if (!mAcked) begin
                if (bus_reqack_in) begin mAcked = 1; eBusReq = 0; end
            end else if (!mOwner) begin
                if (!eRespcyc && bus_respcyc_in && bus_resptag_in == cur.tag) begin
                    eRespcyc = 1; eRespack = 1;
                end else if (eRespcyc && rd_respack_in) begin
                    eRespcyc = 0; mBusy = 0; nReads++;
                end
            end else if (bus_writeack_in) begin
                eWrDone = 1; mBusy = 0; nWrites++;
            end
            eBusy = mBusy;
        end
    end

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkAllZero("reset_state");

        @(posedge clk); #1;
        reset = 1;
        randomMode = 1;
        repeat (3000) @(posedge clk);
        randomMode = 0;
        for (int i = 0; i < 200 && (mBusy || rd_reqcyc_in || wr_reqcyc_in); i++) @(negedge clk);
        @(negedge clk);
        chkBit("drained", mBusy || rd_reqcyc_in || wr_reqcyc_in, 1'b0);
        chk64("rd_queue_empty", 64'(rdQ.size()), 64'd0);
        chk64("wr_queue_empty", 64'(wrQ.size()), 64'd0);
        chkBit("reads_seen", nReads > 20, 1'b1);
        chkBit("writes_seen", nWrites > 20, 1'b1);

        // watchdog: cache withholds its ack
        cacheHold = 1;
        @(posedge clk); #1;
        issueRead(64'h1000, 13'h05);
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chkBit("error_before_timeout", error_out, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chkBit("error_at_timeout", error_out, 1'b1);
        cacheHold = 0;
        n0 = nReads;
        for (int i = 0; i < 60 && nReads == n0; i++) @(negedge clk);
        chkBit("timeout_read_done", nReads > n0, 1'b1);
        repeat (3) @(negedge clk);
        chkBit("error_sticky", error_out, 1'b1);

        // reset while waiting on a write ack
        wrHold = 1;
        @(posedge clk); #1;
        issueWrite(64'h2000, 13'h09, 64'h55);
        repeat (6) @(posedge clk);
        #1;
        chkBit("wait_wr_busy", busy_out, 1'b1);
        reset = 0;
        #2;
        chkAllZero("async_reset");
        wrHold = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        issueRead(64'h3000, 13'h05);
        n0 = nReads;
        for (int i = 0; i < 40 && nReads == n0; i++) @(negedge clk);
        chkBit("post_reset_read_done", nReads > n0, 1'b1);
        repeat (3) @(negedge clk);
        chkBit("error_after_reset", error_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end
endmodule
